sort_sched: RTL
===============

Name: sort_sched

Overview:
- Round-robin scheduler that shares one sorting engine (10-word AXI-stream in, registered `data_out`/`w_fifo_en` out, `done_sorting` pulse) between NUM_REQ requester streams.
- Grants one job at a time and pulses the engine start.
- Feeds exactly JOB_LEN words from the winner into the engine.
- Buffers the engine's unthrottled output, then returns it on a backpressured result stream tagged with the requester ID.

Parameters:
- NUM_REQ, 2, number of requester streams (2..4)
- DATA_W, 32, word width
- JOB_LEN, 10, words per sort job; must match the engine
- TIMEOUT, 64, cycles allowed in WAIT before abort (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_tvalid  in  NUM_REQ  per-requester valid
- s_tdata  in  NUM_REQ*DATA_W  packed requester data; slice i belongs to requester i
- s_tlast  in  NUM_REQ  per-requester last
- s_tready  out  NUM_REQ  per-requester ready
- ap_start_sorting  out  1  one-cycle engine start
- sm_tvalid  out  1  engine stream valid
- sm_tdata  out  DATA_W  engine stream data
- sm_tlast  out  1  engine stream last
- sm_tready  in  1  engine ready
- sort_data  in  DATA_W  engine result word
- sort_wen  in  1  engine result strobe
- sort_done  in  1  engine completion pulse
- m_tvalid  out  1  result valid
- m_tdata  out  DATA_W  result data
- m_tlast  out  1  result last
- m_tid  out  clog2(NUM_REQ)  owning requester
- m_tready  in  1  result ready
- busy  out  1  not IDLE
- err_len  out  NUM_REQ  sticky: requester tlast position mismatched JOB_LEN
- err_ovf  out  1  sticky: result strobe while buffer full

Behaviour:
- Reset: every output is 0; state IDLE; last_grant = NUM_REQ-1; buffer empty; beat counter 0; sticky flags cleared. Reset mid-job aborts immediately; the engine must be reset at the same time.
- IDLE:
  - Arbitrate among asserted s_tvalid, searching from last_grant+1 with wrap.
  - Register grant and last_grant.
  - Go to START the next cycle. No s_tready is given in IDLE.
- START:
  - ap_start_sorting=1 for exactly one cycle.
  - Clear the buffer and beat counter.
  - Go to FEED.
- FEED:
  - Combinational pass-through: sm_tvalid = s_tvalid[grant], sm_tdata = slice[grant], s_tready[grant] = sm_tready; all other s_tready bits are 0.
  - sm_tlast = (beat == JOB_LEN-1). It is generated from the counter; requester tlast is not forwarded.
  - Beat increments on sm_tvalid&sm_tready.
  - A requester tlast on any beat other than JOB_LEN-1, or no tlast on beat JOB_LEN-1, sets err_len[grant]. The beat is still counted.
  - On handshake of beat JOB_LEN-1, go to WAIT.
- WAIT:
  - Each sort_wen cycle writes sort_data into the buffer.
  - A strobe while the buffer holds JOB_LEN words is dropped and sets err_ovf.
  - sort_done coincides with the final strobe; that word is captured, then go to DRAIN.
- DRAIN:
  - m_tvalid=1 while the buffer is non-empty.
  - m_tdata = head entry; m_tlast on the last entry; m_tid = grant.
  - Pop on m_tvalid&m_tready.
  - After popping the last entry, go to IDLE.
  - If sort_done arrived with fewer than JOB_LEN words, m_tlast marks the last stored word.
- Simultaneous events:
  - New requests arriving during a job wait in IDLE arbitration; s_tvalid is never dropped.
  - An m_tready stall holds m_tdata stable.
- Latency: grant to ap_start is 1 cycle; ap_start to first sm_tready follows the engine (2 cycles); result to m_tvalid is 1 cycle after sort_done.

Optional Feature:
- Macro: SORT_SCHED_TIMEOUT_EN.
- Defined:
  - Adds a cycle counter in WAIT.
  - When it reaches TIMEOUT without sort_done, the block returns to IDLE and discards the buffer.
  - Adds output port timeout (1 bit), which pulses for one cycle at abort; reset value 0.
- Undefined: no counter and no port; WAIT waits indefinitely.

Decomposition:
- Package sort_pkg: state encoding (IDLE, START, FEED, WAIT, DRAIN), JOB_LEN default, clog2 helper constant for the ID width.
- Sub-module sort_res_buf: synchronous FIFO of depth JOB_LEN and width DATA_W.
  - Ports: push, pop, clear, full, empty, count, head data.
  - Overflow and empty-pop are guarded inside.

Test Plan:
1. Requester 0 sends 10,9,...,1 with tlast on beat 9 -> m_tdata 1..10, m_tlast on 10, m_tid=0, err_len=0, busy falls after the last pop.
2. Both requesters valid from reset -> requester 0 is served first, then requester 1; a third pending job on requester 0 is served next (round-robin).
3. m_tready toggled 1,0,0,1,... during DRAIN -> no data lost or duplicated; m_tdata stable while stalled; ten beats total.
4. Requester 1 asserts tlast on beat 4 -> err_len=2'b10; the job still consumes 10 beats and returns 10 sorted words.
5. rst_n pulsed low mid-FEED (beat 5) -> all outputs 0 within the reset; next job starts cleanly from IDLE with last_grant=NUM_REQ-1.
6. With SORT_SCHED_TIMEOUT_EN and TIMEOUT=64, sort_done withheld -> one-cycle timeout pulse 64 cycles after entering WAIT; busy=0; m_tvalid never asserted.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the sort scheduler: FSM states, job length, ID width.
// Optional WAIT-state abort is enabled with SORT_SCHED_TIMEOUT_EN.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    WAIT,
    DRAIN
  } state_t;

  localparam int JOB_LEN_DEF = 10;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_res_buf.sv
// Result buffer: synchronous FIFO holding one sorted job.
// Pushes while full and pops while empty are ignored.
module sort_res_buf
  import sort_pkg::*;
#(
  parameter int DEPTH = JOB_LEN_DEF,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = id_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr;
  logic [PW-1:0]    rd;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd];

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else if (clear) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr] <= din;
  end

endmodule

// File: rtl/sort_sched.sv
// Round-robin scheduler sharing one sort engine among NUM_REQ streams.
// Define SORT_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module sort_sched
  import sort_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int JOB_LEN = JOB_LEN_DEF
`ifdef SORT_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        s_tvalid,
  input  logic [NUM_REQ*DATA_W-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]        s_tlast,
  output logic [NUM_REQ-1:0]        s_tready,
  output logic                      ap_start_sorting,
  output logic                      sm_tvalid,
  output logic [DATA_W-1:0]         sm_tdata,
  output logic                      sm_tlast,
  input  logic                      sm_tready,
  input  logic [DATA_W-1:0]         sort_data,
  input  logic                      sort_wen,
  input  logic                      sort_done,
  output logic                      m_tvalid,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast,
  output logic [id_w(NUM_REQ)-1:0]  m_tid,
  input  logic                      m_tready,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        err_len,
  output logic                      err_ovf
`ifdef SORT_SCHED_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  localparam int IDW = id_w(NUM_REQ);
  localparam int BW  = id_w(JOB_LEN);
  localparam int CW  = $clog2(JOB_LEN + 1);

  state_t           state;
  state_t           nxt;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   idx;
  logic             found;
  logic [BW-1:0]    beat;
  logic             last_beat;
  logic             hs_in;
  logic             abort;
  logic             buf_push;
  logic             buf_pop;
  logic             buf_clear;
  logic             buf_full;
  logic             buf_empty;
  logic [CW-1:0]    buf_cnt;
  logic [DATA_W-1:0] buf_head;

  assign last_beat = (beat == BW'(JOB_LEN - 1));
  assign hs_in     = (state == FEED) & s_tvalid[grant] & sm_tready;
  assign buf_push  = (state == WAIT) & sort_wen;
  assign buf_pop   = (state == DRAIN) & ~buf_empty & m_tready;
  assign buf_clear = (state == START) | abort;

  // Rotating priority: start one past the previous winner.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && s_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef SORT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt    <= (state == WAIT) ? tcnt + 1'b1 : '0;
      timeout <= abort;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt              = state;
    abort            = 1'b0;
    s_tready         = '0;
    ap_start_sorting = 1'b0;
    sm_tvalid        = 1'b0;
    sm_tdata         = '0;
    sm_tlast         = 1'b0;
    m_tvalid         = 1'b0;
    m_tdata          = '0;
    m_tlast          = 1'b0;
    m_tid            = '0;
    busy             = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (found) nxt = START;
      end
      START: begin
        ap_start_sorting = 1'b1;
        nxt = FEED;
      end
      FEED: begin
        sm_tvalid       = s_tvalid[grant];
        sm_tdata        = s_tdata[int'(grant)*DATA_W +: DATA_W];
        sm_tlast        = last_beat;
        s_tready[grant] = sm_tready;
        if (hs_in && last_beat) nxt = WAIT;
      end
      WAIT: begin
        if (sort_done) nxt = DRAIN;
`ifdef SORT_SCHED_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          nxt   = IDLE;
          abort = 1'b1;
        end
`endif
      end
      DRAIN: begin
        m_tvalid = ~buf_empty;
        m_tdata  = buf_empty ? '0 : buf_head;
        m_tlast  = (buf_cnt == CW'(1));
        m_tid    = grant;
        if (buf_empty || (buf_pop && buf_cnt == CW'(1)))
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      beat       <= '0;
      err_len    <= '0;
      err_ovf    <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        grant      <= pick;
        last_grant <= pick;
      end
      if (state == START) beat <= '0;
      else if (hs_in)     beat <= beat + 1'b1;
      // Framing error still counts the beat; length comes from the counter.
      if (hs_in && (s_tlast[grant] != last_beat))
        err_len[grant] <= 1'b1;
      if (buf_push && buf_full) err_ovf <= 1'b1;
    end
  end

  sort_res_buf #(
    .DEPTH (JOB_LEN),
    .WIDTH (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (buf_clear),
    .din   (sort_data),
    .head  (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_cnt)
  );

endmodule
